// File: rtl/cgia_shifter.sv
// cgia_shifter: serialises CGIA line-buffer words into a 1 bpp pixel stream, MSB first.
// Optional horizontal fine scroll (hscroll_i) when CGIA_SHIFTER_HSCROLL_EN is defined.
module cgia_shifter #(
    parameter int LB_AW = 6
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             hsync_i,
    input  logic             vsync_i,
    input  logic             den_i,
    input  logic             hact_i,
    input  logic [8:0]       line_len_i,
`ifdef CGIA_SHIFTER_HSCROLL_EN
    input  logic [3:0]       hscroll_i,
`endif
    output logic             lb_bank_o,
    output logic [LB_AW-1:0] lb_adr_o,
    input  logic [15:0]      lb_dat_i,
    output logic             pixel_o,
    output logic             pen_o
);
    typedef enum logic [2:0] {IDLE, PRIME, READY, SHIFT, DONE} state_t;
    localparam logic [8:0] MAX_LEN = 9'(2 ** LB_AW);
    state_t      state;
    logic        hs_q, pend, hs_rise, hs_fall;
    logic [15:0] sr, nxt, cur;
    logic [3:0]  bitcnt, hide, scroll;
    logic [8:0]  wordcnt, nxt_wc, len;
    assign hs_rise = hsync_i & ~hs_q;
    assign hs_fall = ~hsync_i & hs_q;
    assign len     = (line_len_i > MAX_LEN) ? MAX_LEN : line_len_i;
    assign nxt_wc  = wordcnt + 9'd1;
    // bitcnt wraps to 0 once a word is fully shifted; the next pixel then comes from nxt
    assign cur     = (bitcnt == 4'd0) ? nxt : sr;
`ifdef CGIA_SHIFTER_HSCROLL_EN
    assign scroll  = hscroll_i;
`else
    assign scroll  = 4'd0;
`endif
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state     <= IDLE;
            hs_q      <= 1'b0;
            pend      <= 1'b0;
            sr        <= '0;
            nxt       <= '0;
            bitcnt    <= '0;
            hide      <= '0;
            wordcnt   <= '0;
            lb_bank_o <= 1'b0;
            lb_adr_o  <= '0;
            pixel_o   <= 1'b0;
            pen_o     <= 1'b0;
        end else begin
            hs_q    <= hsync_i;
            pend    <= 1'b0;
            pixel_o <= 1'b0;
            pen_o   <= 1'b0;
            if (pend) nxt <= lb_dat_i;
            if (vsync_i) begin
                state     <= IDLE;
                lb_bank_o <= 1'b0;
            end else begin
                if (hs_rise && den_i) lb_bank_o <= ~lb_bank_o;
                case (state)
                    IDLE: if (hs_fall && den_i && len != 9'd0) begin
                        lb_adr_o <= '0;
                        state    <= PRIME;
                    end
                    PRIME: begin
                        nxt   <= lb_dat_i;
                        state <= hs_rise ? IDLE : READY;
                    end
                    READY: if (hs_rise) state <= IDLE;
                    else if (hact_i) begin
                        pixel_o <= nxt[15] & (scroll == 4'd0);
                        pen_o   <= (scroll == 4'd0);
                        hide    <= (scroll == 4'd0) ? 4'd0 : scroll - 4'd1;
                        sr      <= nxt << 1;
                        bitcnt  <= 4'd1;
                        wordcnt <= 9'd1;
                        if (len > 9'd1) begin
                            lb_adr_o <= LB_AW'(1);
                            pend     <= 1'b1;
                        end
                        state <= SHIFT;
                    end
                    SHIFT: if (!hact_i || (bitcnt == 4'd0 && wordcnt >= len)) state <= DONE;
                    else begin
                        pixel_o <= cur[15] & (hide == 4'd0);
                        pen_o   <= (hide == 4'd0);
                        hide    <= (hide == 4'd0) ? 4'd0 : hide - 4'd1;
                        sr      <= cur << 1;
                        bitcnt  <= bitcnt + 4'd1;
                        if (bitcnt == 4'd0) begin
                            wordcnt <= nxt_wc;
                            if (nxt_wc < len) begin
                                lb_adr_o <= LB_AW'(nxt_wc);
                                pend     <= 1'b1;
                            end
                        end
                    end
                    DONE: if (hs_rise) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_cgia_shifter.sv
// tb_cgia_shifter: scoreboard bench for cgia_shifter; expected pixels are queued with their cycle.
module tb_cgia_shifter;
    logic        clk = 1'b0, reset = 1'b0, hsync = 1'b0, vsync = 1'b0, den = 1'b0, hact = 1'b0;
    logic [8:0]  line_len = '0;
    logic [3:0]  hscroll = '0;
    logic        lb_bank, pixel, pen;
    logic [5:0]  lb_adr;
    logic [15:0] mem [64];
    logic [15:0] lb_dat;
    int          cyc = 0, total = 0, bad = 0;
    typedef struct {int cyc; logic pix;} exp_t;
    exp_t sb[$];

    assign lb_dat = mem[lb_adr];

    cgia_shifter #(.LB_AW(6)) dut (
        .clk_i(clk),
        .reset_i(reset),
        .hsync_i(hsync),
        .vsync_i(vsync),
        .den_i(den),
        .hact_i(hact),
        .line_len_i(line_len),
`ifdef CGIA_SHIFTER_HSCROLL_EN
        .hscroll_i(hscroll),
`endif
        .lb_bank_o(lb_bank),
        .lb_adr_o(lb_adr),
        .lb_dat_i(lb_dat),
        .pixel_o(pixel),
        .pen_o(pen)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pen === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL extra_pixel cyc=%0d pixel=%b want=no pixel", cyc, pixel);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (pixel !== e.pix || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL pixel got=%b@%0d want=%b@%0d", pixel, cyc, e.pix, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [63:0] bits, input int n, input int first);
        for (int i = 0; i < n; i++) sb.push_back('{first + i, bits[n-1-i]});
    endtask

    task automatic hs_pulse();
        hsync = 1'b1;
        tick(2);
        hsync = 1'b0;
        tick(2);
    endtask

    task automatic run_line(input int n);
        hact = 1'b1;
        tick(n);
        hact = 1'b0;
        tick(3);
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_bank"}, lb_bank, 0);
        chk({tag, "_adr"}, lb_adr, 0);
        chk({tag, "_pix"}, pixel, 0);
        chk({tag, "_pen"}, pen, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        tick(2);
        chk_idle_outs("rst");
        reset = 1'b1;
        tick(5);
        chk_idle_outs("post_rst");

        // basic two-word line with a longer active region
        mem[0] = 16'hA5F0;
        mem[1] = 16'h8001;
        den = 1'b1;
        line_len = 9'd2;
        hs_pulse();
        chk("basic_bank", lb_bank, 1);
        chk("basic_adr0", lb_adr, 0);
        push(64'b1010010111110000_1000000000000001, 32, cyc + 1);
        run_line(40);
        chk("basic_adr1", lb_adr, 1);
        chk("basic_sb_empty", sb.size(), 0);

        vsync = 1'b1;
        tick(2);
        chk("vs_bank", lb_bank, 0);
        vsync = 1'b0;
        tick(1);
        hs_pulse();
        chk("swap1", lb_bank, 1);
        hs_pulse();
        chk("swap2", lb_bank, 0);
        hs_pulse();
        chk("swap3", lb_bank, 1);
        den = 1'b0;
        hs_pulse();
        chk("noden_bank", lb_bank, 1);
        run_line(5);
        chk("noden_sb_empty", sb.size(), 0);
        vsync = 1'b1;
        tick(1);
        chk("vs_bank2", lb_bank, 0);
        vsync = 1'b0;
        tick(1);

        // truncated active region
        mem[0] = 16'h1234;
        mem[1] = 16'hC3C3;
        mem[2] = 16'hFFFF;
        mem[3] = 16'h0000;
        den = 1'b1;
        line_len = 9'd4;
        hs_pulse();
        push(64'b0001_0010_0011_0100_1100, 20, cyc + 1);
        run_line(20);
        chk("trunc_adr", lb_adr, 2);
        chk("trunc_sb_empty", sb.size(), 0);
        run_line(5);
        chk("done_adr_hold", lb_adr, 2);
        chk("done_pen", pen, 0);

        // reset during a line
        mem[0] = 16'hA5F0;
        line_len = 9'd2;
        hs_pulse();
        push(64'b10100, 5, cyc + 1);
        hact = 1'b1;
        tick(5);
        reset = 1'b0;
        tick(1);
        chk_idle_outs("midrst");
        reset = 1'b1;
        hact = 1'b0;
        tick(2);
        chk("midrst_sb_empty", sb.size(), 0);

        // zero line length
        line_len = 9'd0;
        hs_pulse();
        hact = 1'b1;
        tick(10);
        chk("zero_pen", pen, 0);
        chk("zero_adr", lb_adr, 0);
        hact = 1'b0;
        tick(2);
        chk("zero_sb_empty", sb.size(), 0);

`ifdef CGIA_SHIFTER_HSCROLL_EN
        mem[0] = 16'hFFFF;
        line_len = 9'd1;
        hscroll = 4'd3;
        hs_pulse();
        push(64'h1FFF, 13, cyc + 4);
        run_line(20);
        chk("scroll_sb_empty", sb.size(), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
